serial_reg_bridge: RTL and testbench
====================================

Name: serial_reg_bridge

Overview:
- Byte-level command decoder that sits directly downstream of the SPI-style serial slave.
- Consumes each received byte and its "received" level, decodes a 1-byte command plus a data byte, and maintains a bank of 8-bit control registers.
- Drives the slave's send-data input so that read data is shifted out in the byte slot that follows the command.

Parameters:
- NREG, 16, number of 8-bit registers (1..128).
- TIMEOUT, 1024, clk cycles without a new byte before an open transaction is abandoned (1..65535).
- IDLE_BYTE, 8'h5A, value presented on tx_data when no read data is pending.

Ports:
- clk  in  1  system clock; same clock that samples SCK in the slave.
- res  in  1  asynchronous reset, active-high.
- rx_data  in  8  received byte from the slave; stable while rx_valid is high.
- rx_valid  in  1  slave's received level; high from the 8th SCK rising edge to the following falling edge; SCK-derived, asynchronous to clk.
- tx_data  out  8  byte for the slave's send input; the slave loads it on the falling SCK edge that ends rx_valid.
- reg_q  out  NREG*8  flattened register contents; register i is at bits [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse per completed register write.
- wr_addr  out  7  address of the last write; valid with wr_strobe and held afterwards.
- timeout  out  1  one-cycle pulse when an open transaction is abandoned.

Behaviour:
- Reset:
  - tx_data = IDLE_BYTE, all reg_q = 0, wr_strobe = 0, wr_addr = 0, timeout = 0.
  - State = CMD, internal address = 0, timer = 0, synchronizer flops = 0.
- Byte capture:
  - rx_valid passes through a 2-flop synchronizer, then a rising-edge detect.
  - On a detected edge, rx_data is sampled as byte_evt, 3 clk after the rx_valid rise.
  - tx_data is updated in the same cycle that byte_evt is processed, i.e. 4 clk after the rx_valid rise.
  - Requirement on the system: the SCK high phase must be ≥ 8 clk.
- Command byte:
  - bit7 = 1 means write, 0 means read.
  - bits[6:0] = address.
- States:
  - CMD:
    - Write command: latch address, go to WDATA; tx_data = IDLE_BYTE.
    - Read command: latch address; tx_data = reg[addr], or 8'h00 if addr ≥ NREG; go to RDATA.
  - WDATA:
    - Next byte is written to reg[addr] if addr < NREG, with wr_strobe = 1 for one cycle and wr_addr = addr.
    - If addr ≥ NREG, the byte is discarded and there is no strobe.
    - Go to CMD; tx_data = IDLE_BYTE.
  - RDATA:
    - Next byte (dummy, master-supplied) is ignored.
    - Go to CMD; tx_data = IDLE_BYTE.
- Timer:
  - Clears on every byte_evt and in CMD.
  - In WDATA/RDATA it counts clk; on reaching TIMEOUT: state = CMD, tx_data = IDLE_BYTE, timeout pulses 1 cycle.
  - If byte_evt and timer expiry occur in the same cycle, the byte wins and no timeout pulse is generated.
- Address comparison: the full 7 bits are compared against NREG; there is no aliasing.
- Reset asserted mid-transaction: all state and outputs return to reset values immediately; a partially received frame is lost.
- A register read returns the value including any write completed in a previous frame. There is no same-cycle read/write hazard, because only one byte_evt is processed per cycle.

Optional Feature:
- SERIAL_REG_AUTOINC_EN defined: burst mode.
  - WDATA stays in WDATA after each write, with address incrementing by 1 and wrapping 127→0. Each further byte writes the next register.
  - RDATA stays in RDATA: each dummy byte increments the address and loads tx_data with the new register (or 8'h00 if out of range).
  - A burst ends only by timeout or reset.
- SERIAL_REG_AUTOINC_EN undefined: single-transfer behaviour exactly as in Behaviour; the increment logic is absent.

Test Plan:
- Reset with res = 1 -> tx_data = 8'h5A, reg_q all 0, wr_strobe = 0, state CMD.
- Bytes 8'h83, 8'hC4 -> reg[3] = 8'hC4, wr_strobe pulses once with wr_addr = 3, tx_data = 8'h5A after each byte.
- After the previous test, send read command 8'h03 -> tx_data = 8'hC4 within 4 clk of the rx_valid rise; dummy 8'h00 -> tx_data = 8'h5A, reg unchanged.
- Write 8'hFF (addr 127 ≥ 16) then 8'h11 -> no wr_strobe, reg_q unchanged; read 8'h7F -> tx_data = 8'h00.
- Send 8'h85, then no byte for 1024 clk -> timeout pulses once, state CMD; next byte 8'h22 is decoded as a read command of addr 0x22 (tx_data = 8'h00), not as write data.
- With SERIAL_REG_AUTOINC_EN defined: 8'h8E, 8'hA1, 8'hA2, 8'hA3 -> reg[14] = A1, reg[15] = A2, addr 16 discarded, exactly two wr_strobes; read 8'h0E + dummy -> tx_data sequence C? no: tx_data = 8'hA1 then 8'hA2.

Source files
------------

// File: rtl/serial_reg_bridge.sv
// Byte-level command decoder behind an SPI-style slave: 1-byte command + data byte into a
// register bank. Optional burst mode (auto-increment) enabled by SERIAL_REG_AUTOINC_EN.
module serial_reg_bridge #(
  parameter int unsigned NREG      = 16,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  IDLE_BYTE = 8'h5A
) (
  input  logic              clk,
  input  logic              res,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic [NREG*8-1:0] reg_q,
  output logic              wr_strobe,
  output logic [6:0]        wr_addr,
  output logic              timeout
);

  localparam logic [7:0]  NRegB       = 8'(NREG);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StCmd, StWdata, StRdata} state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        evt_q, evt_d;
  logic [7:0]  byte_q, byte_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  regs_q [NREG];
  logic [7:0]  regs_d [NREG];

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NRegB;
  endfunction

  // Full 7-bit compare: addresses at or above NREG read as zero, never alias.
  function automatic logic [7:0] rd_reg(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (a == 7'(i)) r = regs_q[i];
    end
    return r;
  endfunction

  always_comb begin
    evt_d  = sync2_q & ~sync3_q;
    byte_d = evt_d ? rx_data : byte_q;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    tx_data_d   = tx_data_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    timeout_d   = 1'b0;
    regs_d      = regs_q;

    if (evt_q) begin
      // A byte always beats a coincident timer expiry.
      timer_d = '0;
      unique case (state_q)
        StCmd: begin
          addr_d = byte_q[6:0];
          if (byte_q[7]) begin
            state_d   = StWdata;
            tx_data_d = IDLE_BYTE;
          end else begin
            state_d   = StRdata;
            tx_data_d = rd_reg(byte_q[6:0]);
          end
        end
        StWdata: begin
          if (in_range(addr_q)) begin
            for (int unsigned i = 0; i < NREG; i++) begin
              if (addr_q == 7'(i)) regs_d[i] = byte_q;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end
          tx_data_d = IDLE_BYTE;
`ifdef SERIAL_REG_AUTOINC_EN
          addr_d = addr_q + 7'd1;
`else
          state_d = StCmd;
`endif
        end
        StRdata: begin
`ifdef SERIAL_REG_AUTOINC_EN
          addr_d    = addr_q + 7'd1;
          tx_data_d = rd_reg(addr_q + 7'd1);
`else
          state_d   = StCmd;
          tx_data_d = IDLE_BYTE;
`endif
        end
        default: begin
          state_d   = StCmd;
          tx_data_d = IDLE_BYTE;
        end
      endcase
    end else if (state_q != StCmd) begin
      if (timer_q == TimeoutLast) begin
        state_d   = StCmd;
        timer_d   = '0;
        tx_data_d = IDLE_BYTE;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + 16'd1;
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      evt_q       <= 1'b0;
      byte_q      <= '0;
      state_q     <= StCmd;
      addr_q      <= '0;
      timer_q     <= '0;
      tx_data_q   <= IDLE_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      timeout_q   <= 1'b0;
      regs_q      <= '{default: '0};
    end else begin
      sync1_q     <= rx_valid;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      evt_q       <= evt_d;
      byte_q      <= byte_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      timeout_q   <= timeout_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
    assign reg_q[8*gi +: 8] = regs_q[gi];
  end

  assign tx_data   = tx_data_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Self-checking bench for serial_reg_bridge: directed vector table, timeout/reset sequences
// and randomized bytes checked against a transaction-level model.
module tb_serial_reg_bridge;

  localparam int          NREG    = 16;
  localparam int          TIMEOUT = 1024;
  localparam logic [7:0]  IDLE    = 8'h5A;
  localparam int          LONG    = TIMEOUT + 20;

  logic              clk = 1'b0;
  logic              res;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic [NREG*8-1:0] reg_q;
  logic              wr_strobe;
  logic [6:0]        wr_addr;
  logic              timeout;

  serial_reg_bridge #(.NREG(NREG), .TIMEOUT(TIMEOUT), .IDLE_BYTE(IDLE)) dut (
    .clk      (clk),
    .res      (res),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .reg_q    (reg_q),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stb_seen = 0;
  int to_seen = 0;

  // Transaction-level model: mode 0 = expecting command, 1 = write data, 2 = read dummy.
  logic [7:0] mregs [NREG];
  int         mmode, maddr, mwaddr, nstb, nto;
  logic [7:0] mtx;

  typedef struct {
    logic [7:0] b;
    int         gap;
    logic [7:0] tx;
    logic       stb;
    logic [6:0] waddr;
  } vec_t;

  vec_t vecs[$];

  always @(negedge clk) begin
    if (!res) begin
      if (wr_strobe) stb_seen++;
      if (timeout) to_seen++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] f;
    for (int i = 0; i < NREG; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  function automatic logic [7:0] mrd(input int a);
    return (a < NREG) ? mregs[a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
    mmode = 0;
    maddr = 0;
    mwaddr = 0;
    mtx = IDLE;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic stb);
    stb = 1'b0;
    case (mmode)
      0: begin
        maddr = int'(b[6:0]);
        if (b[7]) begin
          mmode = 1;
          mtx = IDLE;
        end else begin
          mmode = 2;
          mtx = mrd(maddr);
        end
      end
      1: begin
        if (maddr < NREG) begin
          mregs[maddr] = b;
          stb = 1'b1;
          mwaddr = maddr;
          nstb++;
        end
        mtx = IDLE;
`ifdef SERIAL_REG_AUTOINC_EN
        maddr = (maddr + 1) % 128;
`else
        mmode = 0;
`endif
      end
      default: begin
`ifdef SERIAL_REG_AUTOINC_EN
        maddr = (maddr + 1) % 128;
        mtx = mrd(maddr);
`else
        mmode = 0;
        mtx = IDLE;
`endif
      end
    endcase
  endtask

  // One byte frame: rx_valid high 10 clk, outputs sampled just after the 4th edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output logic [7:0] got_tx,
                           output logic got_stb, output logic [6:0] got_waddr);
    logic stb;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    got_tx = tx_data;
    got_stb = wr_strobe;
    got_waddr = wr_addr;
    model_byte(b, stb);
    chk("tx_data", tx_data, mtx);
    chk("wr_strobe", wr_strobe, stb);
    if (stb) chk("wr_addr", wr_addr, 7'(mwaddr));
    chk("reg_q", reg_q, mflat());
    repeat (6) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    if (gap > TIMEOUT) begin
      if (mmode != 0) begin
        mmode = 0;
        mtx = IDLE;
        nto++;
      end
      chk("timeout_count", to_seen, nto);
      chk("tx_after_gap", tx_data, mtx);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] gtx;
    logic       gstb;
    logic [6:0] gwa;
    logic [7:0] b;
    int         gap;

    nstb = 0;
    nto = 0;
    model_reset();
    res = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx_data, 8'h5A);
    chk("reset_regs", reg_q, '0);
    chk("reset_strobe", wr_strobe, 1'b0);
    chk("reset_waddr", wr_addr, 7'd0);
    chk("reset_timeout", timeout, 1'b0);
    @(negedge clk);
    res = 1'b0;

`ifndef SERIAL_REG_AUTOINC_EN
    vecs.push_back('{8'h83, 3, 8'h5A, 1'b0, 7'd0});
    vecs.push_back('{8'hC4, 3, 8'h5A, 1'b1, 7'd3});
    vecs.push_back('{8'h03, 3, 8'hC4, 1'b0, 7'd0});
    vecs.push_back('{8'h00, 3, 8'h5A, 1'b0, 7'd0});
    vecs.push_back('{8'hFF, 3, 8'h5A, 1'b0, 7'd0});
    vecs.push_back('{8'h11, 3, 8'h5A, 1'b0, 7'd0});
    vecs.push_back('{8'h7F, 3, 8'h00, 1'b0, 7'd0});
    vecs.push_back('{8'h00, 3, 8'h5A, 1'b0, 7'd0});
`else
    vecs.push_back('{8'h8E, 3, 8'h5A, 1'b0, 7'd0});
    vecs.push_back('{8'hA1, 3, 8'h5A, 1'b1, 7'd14});
    vecs.push_back('{8'hA2, 3, 8'h5A, 1'b1, 7'd15});
    vecs.push_back('{8'hA3, LONG, 8'h5A, 1'b0, 7'd0});
    vecs.push_back('{8'h0E, 3, 8'hA1, 1'b0, 7'd0});
    vecs.push_back('{8'h00, LONG, 8'hA2, 1'b0, 7'd0});
`endif
    foreach (vecs[i]) begin
      send_byte(vecs[i].b, vecs[i].gap, gtx, gstb, gwa);
      chk($sformatf("vec%0d_tx", i), gtx, vecs[i].tx);
      chk($sformatf("vec%0d_strobe", i), gstb, vecs[i].stb);
      if (vecs[i].stb) chk($sformatf("vec%0d_waddr", i), gwa, vecs[i].waddr);
    end
`ifndef SERIAL_REG_AUTOINC_EN
    chk("table_reg3", reg_q[31:24], 8'hC4);
    chk("table_strobes", stb_seen, 1);
    chk("table_timeouts", to_seen, 0);
`else
    chk("table_reg14", reg_q[119:112], 8'hA1);
    chk("table_reg15", reg_q[127:120], 8'hA2);
    chk("table_strobes", stb_seen, 2);
    chk("table_timeouts", to_seen, 2);
`endif

    // Abandoned write: command then silence, next byte must decode as a command.
    begin
      int to_before;
      to_before = to_seen;
      send_byte(8'h85, LONG, gtx, gstb, gwa);
      chk("abandon_timeout_pulses", to_seen - to_before, 1);
      send_byte(8'h22, 3, gtx, gstb, gwa);
      chk("after_timeout_read_tx", gtx, 8'h00);
      chk("after_timeout_no_strobe", gstb, 1'b0);
      send_byte(8'h00, LONG, gtx, gstb, gwa);
    end

    for (int n = 0; n < 150; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[6:0] = 7'($urandom_range(0, 19));
      gap = ($urandom_range(0, 9) == 0) ? LONG : int'($urandom_range(2, 8));
      send_byte(b, gap, gtx, gstb, gwa);
    end

    // Reset in the middle of a write transaction.
    send_byte(8'h81, 3, gtx, gstb, gwa);
    @(negedge clk);
    res = 1'b1;
    model_reset();
    #1;
    chk("midreset_tx", tx_data, 8'h5A);
    chk("midreset_regs", reg_q, '0);
    chk("midreset_waddr", wr_addr, 7'd0);
    chk("midreset_strobe", wr_strobe, 1'b0);
    repeat (2) @(negedge clk);
    res = 1'b0;
    send_byte(8'h42, 3, gtx, gstb, gwa);
    chk("postreset_read_tx", gtx, 8'h00);
    chk("postreset_no_strobe", gstb, 1'b0);
    send_byte(8'h00, LONG, gtx, gstb, gwa);

    repeat (5) @(negedge clk);
    chk("total_strobes", stb_seen, nstb);
    chk("total_timeouts", to_seen, nto);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
